// File: rtl/trans_pkg.sv
// Shared definitions for the N-destination transmission logic.
//   state_e : control FSM states
//   dsel_w  : width of the destination-select field for a given destination count
package trans_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  // At least one select bit, even for the minimum of two destinations.
  function automatic int dsel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/trans_fifo.sv
// Synchronous FIFO with occupancy count and programmable almost-full flag.
// Ports:
//   clk, rst_ni      clock, asynchronous active-low reset (pointers/count only)
//   flush_i          synchronous flush, empties the FIFO at the next edge
//   push_i, wdata_i  write request and data (ignored when full)
//   pop_i            read request (ignored when empty)
//   umbral_i         almost-full threshold
//   rdata_o          current head word (combinational read)
//   count_o          occupancy, one bit wider than the address
//   full_o, empty_o  occupancy flags
//   almost_full_o    count_o >= umbral_i
module trans_fifo #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 4,
  parameter int UMB_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [DATA_W-1:0]      wdata_i,
  input  logic [UMB_W-1:0]       umbral_i,
  output logic [DATA_W-1:0]      rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   almost_full_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int CMP_W = (CW > UMB_W) ? CW : UMB_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full_o        = (count_q == CW'(DEPTH));
  assign empty_o       = (count_q == '0);
  assign count_o       = count_q;
  assign rdata_o       = mem_q[rd_ptr_q];
  assign almost_full_o = (CMP_W'(count_q) >= CMP_W'(umbral_i));

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are exactly AW bits wide so they wrap naturally at DEPTH.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only; the count defines which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/trans_logic_nch.sv
// N-destination transmission logic: a main FIFO whose head word is routed by
// its top DSEL_W bits into one of N_DEST destination FIFOs, each gated by a
// shared programmable threshold, with registered per-destination read ports
// and an idle/active/error control FSM.
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   init                    load thresholds / hold in INIT
//   umbral_main/umbral_dest thresholds latched while in INIT
//   wr_enable, data_in      push into the main FIFO
//   pop                     per-destination read requests
//   data_out, valid_out     registered read data (slice i) and 1-cycle strobes
//   empty                   per-destination empty flags
//   pause                   main occupancy reached umbral_main
//   error_dest              sticky pop-on-empty flags
//   error_out/active_out/idle_out  FSM state indicators
// Configuration macro: TRANS_ERR_CLR_EN -- when defined, init=1 in ERROR
// flushes all FIFOs, clears error_dest and returns to INIT.
module trans_logic_nch
  import trans_pkg::*;
#(
  parameter int DATA_W     = 6,
  parameter int N_DEST     = 4,
  parameter int MAIN_DEPTH = 8,
  parameter int DEST_DEPTH = 4,
  parameter int UMB_W      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init,
  input  logic [UMB_W-1:0]           umbral_main,
  input  logic [UMB_W-1:0]           umbral_dest,
  input  logic                       wr_enable,
  input  logic [DATA_W-1:0]          data_in,
  input  logic [N_DEST-1:0]          pop,
  output logic [N_DEST*DATA_W-1:0]   data_out,
  output logic [N_DEST-1:0]          valid_out,
  output logic [N_DEST-1:0]          empty,
  output logic                       pause,
  output logic [N_DEST-1:0]          error_dest,
  output logic                       error_out,
  output logic                       active_out,
  output logic                       idle_out
);

  localparam int DSEL_W = dsel_w(N_DEST);
  localparam int MCW    = $clog2(MAIN_DEPTH) + 1;
  localparam int DCW    = $clog2(DEST_DEPTH) + 1;

  state_e                        state_q, state_d;
  logic [UMB_W-1:0]              umb_main_q, umb_dest_q;
  logic [N_DEST*DATA_W-1:0]      data_out_q, data_out_d;
  logic [N_DEST-1:0]             valid_q, valid_d;
  logic [N_DEST-1:0]             err_dest_q, err_dest_d;

  logic [DATA_W-1:0]             m_rdata;
  logic [MCW-1:0]                m_count;
  logic                          m_full, m_empty, m_afull, m_push, m_pop;
  logic [N_DEST-1:0][DATA_W-1:0] d_rdata;
  logic [N_DEST-1:0][DCW-1:0]    d_count;
  logic [N_DEST-1:0]             d_full, d_empty, d_afull, d_push, d_pop;

  logic                          clr_req, flush, op_en, operational;
  logic                          wr_err, discard, any_err, all_empty;
  logic [N_DEST-1:0]             pop_err;
  logic [DSEL_W-1:0]             head_dest;
  logic                          dest_ok;
  logic                          unused_counts;

`ifdef TRANS_ERR_CLR_EN
  assign clr_req = (state_q == ST_ERROR) && init;
`else
  assign clr_req = 1'b0;
`endif

  assign flush       = clr_req;
  assign operational = (state_q == ST_IDLE) || (state_q == ST_ACTIVE) || (state_q == ST_ERROR);
  // The datapath is frozen on the flush edge so nothing survives it.
  assign op_en       = operational && !clr_req;

  assign head_dest = m_rdata[DATA_W-1 -: DSEL_W];
  assign dest_ok   = ({1'b0, head_dest} < (DSEL_W+1)'(N_DEST));

  // Push uses the pre-edge full flag: a transfer freeing a slot on the same
  // edge does not let a write into a full main FIFO.
  assign m_push = op_en && wr_enable && !m_full;
  assign wr_err = op_en && wr_enable && m_full;

  assign d_pop   = pop & ~d_empty & {N_DEST{op_en}};
  assign pop_err = pop &  d_empty & {N_DEST{op_en}};

  // Head-of-line routing: only the main head may move; a blocked destination
  // stalls everything behind it.
  always_comb begin
    d_push  = '0;
    m_pop   = 1'b0;
    discard = 1'b0;
    if (op_en && !m_empty) begin
      if (!dest_ok) begin
        m_pop   = 1'b1;
        discard = 1'b1;
      end else if (!d_afull[head_dest] && !d_full[head_dest]) begin
        m_pop             = 1'b1;
        d_push[head_dest] = 1'b1;
      end
    end
  end

  assign any_err   = wr_err || (|pop_err) || discard;
  assign all_empty = m_empty && (&d_empty);

  trans_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (MAIN_DEPTH),
    .UMB_W  (UMB_W)
  ) u_main (
    .clk           (clk),
    .rst_ni        (reset),
    .flush_i       (flush),
    .push_i        (m_push),
    .pop_i         (m_pop),
    .wdata_i       (data_in),
    .umbral_i      (umb_main_q),
    .rdata_o       (m_rdata),
    .count_o       (m_count),
    .full_o        (m_full),
    .empty_o       (m_empty),
    .almost_full_o (m_afull)
  );

  for (genvar i = 0; i < N_DEST; i++) begin : g_dest
    trans_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEST_DEPTH),
      .UMB_W  (UMB_W)
    ) u_dest (
      .clk           (clk),
      .rst_ni        (reset),
      .flush_i       (flush),
      .push_i        (d_push[i]),
      .pop_i         (d_pop[i]),
      .wdata_i       (m_rdata),
      .umbral_i      (umb_dest_q),
      .rdata_o       (d_rdata[i]),
      .count_o       (d_count[i]),
      .full_o        (d_full[i]),
      .empty_o       (d_empty[i]),
      .almost_full_o (d_afull[i])
    );
  end

  // Occupancy is exported by the FIFOs but only the derived flags are needed.
  assign unused_counts = ^{m_count, d_count};

  // Read ports: a successful pop latches the head into its slice for good;
  // the strobe lasts one cycle.
  always_comb begin
    data_out_d = data_out_q;
    valid_d    = '0;
    err_dest_d = err_dest_q;
    if (clr_req) err_dest_d = '0;
    for (int i = 0; i < N_DEST; i++) begin
      if (d_pop[i]) begin
        data_out_d[i*DATA_W +: DATA_W] = d_rdata[i];
        valid_d[i]                     = 1'b1;
      end
      if (pop_err[i]) err_dest_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_q <= '0;
      valid_q    <= '0;
      err_dest_q <= '0;
      umb_main_q <= '0;
      umb_dest_q <= '0;
    end else begin
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      err_dest_q <= err_dest_d;
      if (state_q == ST_INIT) begin
        umb_main_q <= umbral_main;
        umb_dest_q <= umbral_dest;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_RESET;
    else        state_q <= state_d;
  end

  // FSM: next state. IDLE/ACTIVE follow the pre-edge occupancy.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT:  if (!init) state_d = ST_IDLE;
      ST_IDLE, ST_ACTIVE: begin
        if (any_err)        state_d = ST_ERROR;
        else if (all_empty) state_d = ST_IDLE;
        else                state_d = ST_ACTIVE;
      end
      ST_ERROR: if (clr_req) state_d = ST_INIT;
      default:  state_d = ST_RESET;
    endcase
  end

  // FSM: outputs
  always_comb begin
    idle_out   = 1'b0;
    active_out = 1'b0;
    error_out  = 1'b0;
    unique case (state_q)
      ST_IDLE:   idle_out   = 1'b1;
      ST_ACTIVE: active_out = 1'b1;
      ST_ERROR:  error_out  = 1'b1;
      default: ;
    endcase
  end

  // Thresholds are meaningless before they are latched, so pause stays low
  // in RESET and INIT.
  assign pause      = operational && m_afull;
  assign data_out   = data_out_q;
  assign valid_out  = valid_q;
  assign error_dest = err_dest_q;
  assign empty      = d_empty;

endmodule

// File: tb/tb_trans_logic_nch.sv
// Bench for trans_logic_nch: queue-based reference model, per-cycle compare
// of every output, directed scenarios with literal expectations and
// randomized traffic episodes.
module tb_trans_logic_nch;

  localparam int DW = 6;
  localparam int ND = 4;
  localparam int MD = 8;
  localparam int DD = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              init = 1'b0;
  logic [3:0]        umbral_main = '0;
  logic [3:0]        umbral_dest = '0;
  logic              wr_enable = 1'b0;
  logic [DW-1:0]     data_in = '0;
  logic [ND-1:0]     pop = '0;
  logic [ND*DW-1:0]  data_out;
  logic [ND-1:0]     valid_out, empty, error_dest;
  logic              pause, error_out, active_out, idle_out;

  trans_logic_nch #(
    .DATA_W(DW), .N_DEST(ND), .MAIN_DEPTH(MD), .DEST_DEPTH(DD), .UMB_W(4)
  ) dut (
    .clk(clk), .reset(reset), .init(init),
    .umbral_main(umbral_main), .umbral_dest(umbral_dest),
    .wr_enable(wr_enable), .data_in(data_in), .pop(pop),
    .data_out(data_out), .valid_out(valid_out), .empty(empty), .pause(pause),
    .error_dest(error_dest), .error_out(error_out),
    .active_out(active_out), .idle_out(idle_out)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: 0 RESET, 1 INIT, 2 IDLE, 3 ACTIVE, 4 ERROR
  int               st;
  int               umb_m, umb_d;
  logic [DW-1:0]    mq[$];
  logic [DW-1:0]    dq[ND][$];
  logic [ND*DW-1:0] m_dout;
  logic [ND-1:0]    m_vld, m_errd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    st = 0; umb_m = 0; umb_d = 0;
    mq.delete();
    for (int i = 0; i < ND; i++) dq[i].delete();
    m_dout = '0; m_vld = '0; m_errd = '0;
  endtask

  task automatic model_edge();
    int dpre[ND];
    int mpre, d;
    bit op, clr, err, all_empty;
    logic [DW-1:0] w;
    if (!reset) begin
      model_reset();
      return;
    end
    mpre = mq.size();
    all_empty = (mpre == 0);
    for (int i = 0; i < ND; i++) begin
      dpre[i] = dq[i].size();
      if (dpre[i] != 0) all_empty = 0;
    end
    clr = 0;
`ifdef TRANS_ERR_CLR_EN
    clr = (st == 4) && init;
`endif
    op = (st >= 2) && !clr;
    err = 0;
    m_vld = '0;
    if (op) begin
      for (int i = 0; i < ND; i++) begin
        if (pop[i]) begin
          if (dpre[i] > 0) begin
            w = dq[i].pop_front();
            m_dout[i*DW +: DW] = w;
            m_vld[i] = 1'b1;
          end else begin
            m_errd[i] = 1'b1;
            err = 1;
          end
        end
      end
      if (mpre > 0) begin
        w = mq[0];
        d = int'(w[DW-1 -: 2]);
        if (dpre[d] < umb_d && dpre[d] < DD) begin
          w = mq.pop_front();
          dq[d].push_back(w);
        end
      end
      if (wr_enable) begin
        if (mpre < MD) mq.push_back(data_in);
        else err = 1;
      end
    end
    case (st)
      0: st = 1;
      1: begin
        umb_m = int'(umbral_main);
        umb_d = int'(umbral_dest);
        if (!init) st = 2;
      end
      2, 3: st = err ? 4 : (all_empty ? 2 : 3);
      4: if (clr) begin
        mq.delete();
        for (int i = 0; i < ND; i++) dq[i].delete();
        m_errd = '0;
        st = 1;
      end
      default: st = 0;
    endcase
  endtask

  task automatic check_all();
    logic [ND-1:0] e_empty;
    logic [2:0]    e_flags;
    for (int i = 0; i < ND; i++) e_empty[i] = (dq[i].size() == 0);
    e_flags = (st == 4) ? 3'b100 : (st == 3) ? 3'b010 : (st == 2) ? 3'b001 : 3'b000;
    chk("data_out",   32'(data_out),   32'(m_dout));
    chk("valid_out",  32'(valid_out),  32'(m_vld));
    chk("empty",      32'(empty),      32'(e_empty));
    chk("pause",      32'(pause),      32'((st >= 2) && (mq.size() >= umb_m)));
    chk("error_dest", 32'(error_dest), 32'(m_errd));
    chk("state_flags", 32'({error_out, active_out, idle_out}), 32'(e_flags));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Asserts reset between clock edges and checks the immediate effect.
  task automatic do_reset();
    #2;
    reset = 1'b0; wr_enable = 1'b0; pop = '0; init = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_empty", 32'(empty), 32'(4'b1111));
    chk("rst_outs", 32'({data_out, valid_out, pause, error_dest, error_out, active_out, idle_out}), 32'd0);
    step();
    reset = 1'b1;
  endtask

  task automatic do_init(input logic [3:0] um, input logic [3:0] ud);
    init = 1'b1; umbral_main = um; umbral_dest = ud;
    step();
    step();
    init = 1'b0;
    step();
  endtask

  task automatic push(input logic [DW-1:0] w);
    wr_enable = 1'b1; data_in = w;
    step();
    wr_enable = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    check_all();

    // Routing to two destinations and a pop, with idle/active/idle.
    do_reset();
    do_init(4'd8, 4'd2);
    chk("t2_idle", 32'({error_out, active_out, idle_out}), 32'(3'b001));
    push(6'b00_0001);
    push(6'b01_0010);
    step();
    chk("t2_empty", 32'(empty), 32'(4'b1100));
    chk("t2_active", 32'({error_out, active_out, idle_out}), 32'(3'b010));
    pop = 4'b0001; step();
    chk("t2_dout0", 32'(data_out[5:0]), 32'(6'b000001));
    chk("t2_vld", 32'(valid_out), 32'(4'b0001));
    pop = 4'b0010; step();
    chk("t2_dout1", 32'(data_out[11:6]), 32'(6'b010010));
    pop = '0; step();
    chk("t2_back_idle", 32'({error_out, active_out, idle_out}), 32'(3'b001));

    // Threshold-limited destination, head-of-line backlog and pause.
    do_reset();
    do_init(4'd3, 4'd2);
    for (int k = 1; k <= 5; k++) push({2'b11, 4'(k)});
    chk("t3_pause", 32'(pause), 32'd1);
    pop = 4'b1000; step();
    chk("t3_first", 32'(data_out[23:18]), 32'(6'b110001));
    step();
    chk("t3_second", 32'(data_out[23:18]), 32'(6'b110010));
    pop = '0;
    for (int k = 0; k < 4; k++) step();
    pop = 4'b1000;
    for (int k = 0; k < 3; k++) step();
    chk("t3_last", 32'(data_out[23:18]), 32'(6'b110101));
    pop = '0; step();

    // Pop on an empty destination is sticky.
    do_reset();
    do_init(4'd8, 4'd2);
    pop = 4'b0100; step();
    pop = '0;
    chk("t4_errd", 32'(error_dest), 32'(4'b0100));
    chk("t4_err", 32'(error_out), 32'd1);
    step(); step();
    chk("t4_sticky", 32'({error_dest, error_out}), 32'({4'b0100, 1'b1}));

`ifdef TRANS_ERR_CLR_EN
    init = 1'b1; step();
    chk("t6_errd_clr", 32'(error_dest), 32'd0);
    chk("t6_empty", 32'(empty), 32'(4'b1111));
    chk("t6_flags", 32'({error_out, active_out, idle_out}), 32'd0);
    init = 1'b0; step();
    chk("t6_idle", 32'(idle_out), 32'd1);
`else
    init = 1'b1; step();
    chk("t6_no_clr", 32'({error_dest, error_out}), 32'({4'b0100, 1'b1}));
    init = 1'b0; step();
`endif

    // Main FIFO full with all destinations blocked; the ninth word is dropped.
    do_reset();
    do_init(4'd8, 4'd0);
    for (int k = 0; k < 8; k++) push(6'($urandom));
    chk("t5_pause", 32'(pause), 32'd1);
    chk("t5_no_err", 32'(error_out), 32'd0);
    push(6'b10_1010);
    chk("t5_err", 32'(error_out), 32'd1);

    // Randomized traffic, each episode ended by a reset mid-traffic.
    for (int ep = 0; ep < 5; ep++) begin
      do_reset();
      do_init(4'($urandom_range(1, 9)), 4'($urandom_range(1, 6)));
      for (int c = 0; c < 200; c++) begin
        wr_enable = ($urandom % 3 != 0) && ((mq.size() < MD) || ($urandom % 25 == 0));
        data_in = 6'($urandom);
        for (int i = 0; i < ND; i++)
          pop[i] = (dq[i].size() > 0) ? 1'($urandom % 2) : ($urandom % 60 == 0);
        step();
      end
    end
    do_reset();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
